cd_reply_rr_sched: RTL and testbench
====================================

// Module: cd_reply_rr_sched
// PURPOSE
//  Round-robin scheduler/datapath for the global 4->8 LLC reply path; drop-in replacement for fixed-priority reply mux.
//  Decodes each LLC reply flit's destination output and arbitrates per output with a rotating pointer.
//  Per-requester wait counters escalate any requester blocked STARVE_LIM cycles to absolute priority.
//  Single-flit packets; zero-latency combinational grant; all arbitration state is registered.
// PARAMETERS
//  DATA_W      64  flit width
//  SX_LSB      40  LSB of 8-bit srcx field in flit
//  SY_LSB      32  LSB of 8-bit srcy field in flit
//  STARVE_LIM  8   blocked cycles before starve escalation (>=1); counter width = $clog2(STARVE_LIM+1)
// PORTS
//  clk       in   1         clock, rising edge
//  reset     in   1         synchronous, active-high reset
//  llc_si_r  in   4         reply valid per LLC requester r0..r3
//  llc_ri_r  out  4         reply accepted (transfer when llc_si_r[r] & llc_ri_r[r])
//  llc_di_r  in   4*DATA_W  reply flits, r at [DATA_W*(r+1)-1 : DATA_W*r]
//  out_so    out  8         output valid per output o0..o7
//  out_ro    in   8         downstream ready per output
//  out_do    out  8*DATA_W  output flits, o at [DATA_W*(o+1)-1 : DATA_W*o]
//  starve    out  4         registered: requester r at STARVE_LIM
// BEHAVIOUR
//  - One clock; reset synchronous and active-high.
//  - Destination: dest[r] = {sy[1], sx[1], sy[0]} of flit r (sx = di[SX_LSB+:8], sy = di[SY_LSB+:8]). Quadrant base = {sy[1],sx[1]}*2; link = sy[0].
//  - req[o] = set of r with llc_si_r[r] and dest[r]==o.
//  - Winner for output o, combinational, same cycle:
//    - If any r in req[o] has starve[r]=1: lowest-index starved r wins.
//    - Otherwise: first r in req[o] scanning ptr[o], ptr[o]+1, ... mod 4.
//  - out_so[o] = winner exists & out_ro[o].
//  - llc_ri_r[r] = r is winner of dest[r] & out_ro[dest[r]].
//  - out_do[o] = winner's flit when out_so[o]; otherwise all-zero.
//  - Not-ready output: out_so[o]=0 and its winner gets no ri. Flits never dropped; requesters hold si/di until accepted.
//  - Pointer ptr[o] (2b each): on a transfer from r on o, ptr[o] <= (r+1) mod 4. Otherwise unchanged, including when out_ro[o]=0.
//  - wait_cnt[r]:
//    - Cleared when llc_si_r[r]=0 or on transfer.
//    - Otherwise increments, saturating at STARVE_LIM.
//    - starve[r] is registered (wait_cnt[r]==STARVE_LIM) as seen after the update, so it is visible the following cycle.
//  - Simultaneous events: several outputs may transfer in the same cycle, and every ptr update is independent. A starved winner clears its counter and still updates ptr[o].
//  - Reset (any cycle, including mid-stream):
//    - While reset=1: out_so=0, llc_ri_r=0, out_do=0.
//    - Next edge: all ptr=0, all wait_cnt=0, starve=0. The first post-reset arbitration is fixed-priority r0>r1>r2>r3.
//  - Throughput: up to 4 transfers per cycle when destinations are distinct and ready.
// TESTING
//  1 Distinct targets: r0 sx=00,sy=00; r1 sx=02,sy=01; out_ro=FF -> out_so=00001001, o0=r0 flit, o3=r1 flit, llc_ri_r=0011.
//  2 RR conflict: r0,r1 both sy=11,sx=00 (out5), held 3 cycles -> llc_ri_r=0001, then 0010, then 0001; o5 tags alternate.
//  3 Not ready: r2 sx=03,sy=11 (out7), out_ro=7F -> out_so=0, ri=0, ptr7 stays 0; starve=0100 after 8 blocked cycles.
//  4 Starve override: prime ptr6=2 via r1 transfer on out6 (sx=02,sy=10). Hold r1 to out6 with out_ro[6]=0 for 8 cycles; add r3 to out6; set out_ro[6]=1 -> r1 wins (ri=0010) despite RR selecting r3; starve[1] clears next cycle.
//  5 Full throughput: r0..r3 to out0,out2,out4,out6, out_ro=FF -> ri=1111, out_so=01010101.
//  6 Reset mid-op: reset with starve=0100 and ptr5=1 -> during reset out_so=0, ri=0; after release starve=0 and conflict on out5 is won by r0.

Source files
------------

// File: rtl/cd_reply_rr_sched.sv
// ---------------------------------------------------------------------------
// cd_reply_rr_sched
//
// Round-robin scheduler and datapath for the 4-to-8 LLC reply path. Each of
// the four LLC requesters offers one single-flit reply. The flit's
// destination output is decoded from its srcx/srcy fields. Every output then
// picks one winner from the requesters that target it, in the same cycle.
//
// Arbitration per output:
//   - A starved requester (blocked STARVE_LIM cycles) has absolute priority.
//     If several are starved, the lowest index wins.
//   - Otherwise a rotating pointer decides. After a transfer, the pointer
//     moves to the requester just past the winner.
//
// All arbitration state (pointers, wait counters, starve flags) is
// registered. The grant path is purely combinational.
//
// Ports
//   clk       in   1         clock, rising edge
//   reset     in   1         synchronous, active-high reset
//   llc_si_r  in   4         reply valid per requester r0..r3
//   llc_ri_r  out  4         reply accepted (transfer = si & ri)
//   llc_di_r  in   4*DATA_W  reply flits, requester r at slice r
//   out_so    out  8         output valid per output o0..o7
//   out_ro    in   8         downstream ready per output
//   out_do    out  8*DATA_W  output flits, output o at slice o (zero if idle)
//   starve    out  4         registered: requester r has waited STARVE_LIM
// ---------------------------------------------------------------------------
module cd_reply_rr_sched #(
    parameter int DATA_W     = 64,
    parameter int SX_LSB     = 40,
    parameter int SY_LSB     = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            llc_si_r,
    output logic [3:0]            llc_ri_r,
    input  logic [4*DATA_W-1:0]   llc_di_r,
    output logic [7:0]            out_so,
    input  logic [7:0]            out_ro,
    output logic [8*DATA_W-1:0]   out_do,
    output logic [3:0]            starve
);

    localparam int              CW    = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0]   LIM_C = CW'(STARVE_LIM);

    // Registered arbitration state.
    logic [1:0]    ptr      [8];
    logic [CW-1:0] wait_cnt [4];
    logic [3:0]    starve_q;

    // Combinational decode and arbitration.
    logic [2:0]    dest     [4];
    logic [3:0]    req      [8];
    logic [7:0]    win_vld;
    logic [1:0]    win_idx  [8];
    logic [7:0]    grant;
    logic [CW-1:0] cnt_nxt  [4];

    assign starve = starve_q;
    assign out_so = grant;

    // Destination decode. The quadrant comes from bit 1 of sy and sx. The
    // link within the quadrant is sy[0].
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            dest[r] = {llc_di_r[DATA_W*r + SY_LSB + 1],
                       llc_di_r[DATA_W*r + SX_LSB + 1],
                       llc_di_r[DATA_W*r + SY_LSB]};
        end
    end

    // Per-output winner selection.
    always_comb begin
        logic [3:0] starved_req;
        logic [1:0] idx;
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves a value held (no latch).
        starved_req = '0;
        idx         = '0;
        for (int o = 0; o < 8; o++) begin
            req[o]     = '0;
            win_vld[o] = 1'b0;
            win_idx[o] = '0;
            for (int r = 0; r < 4; r++) begin
                req[o][r] = llc_si_r[r] && (dest[r] == 3'(o));
            end

            starved_req = req[o] & starve_q;
            if (|starved_req) begin
                // A descending scan ends on the lowest starved index.
                for (int r = 3; r >= 0; r--) begin
                    if (starved_req[r]) win_idx[o] = 2'(r);
                end
                win_vld[o] = 1'b1;
            end else if (|req[o]) begin
                // A descending scan over the rotated offsets ends on the
                // requester closest to the pointer. Offsets wrap mod 4
                // through the 2-bit add.
                for (int k = 3; k >= 0; k--) begin
                    idx = ptr[o] + 2'(k);
                    if (req[o][idx]) win_idx[o] = idx;
                end
                win_vld[o] = 1'b1;
            end

            // Reset gates every grant, so nothing moves while it is held.
            grant[o] = win_vld[o] && out_ro[o] && !reset;
        end
    end

    // Accept back to requesters. A requester is accepted only when it is
    // the granted winner of the output its own flit targets.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            llc_ri_r[r] = llc_si_r[r] && grant[dest[r]] &&
                          (win_idx[dest[r]] == 2'(r));
        end
    end

    // Output datapath. An idle output drives zero instead of a stale flit.
    always_comb begin
        out_do = '0;
        for (int o = 0; o < 8; o++) begin
            for (int r = 0; r < 4; r++) begin
                if (grant[o] && (win_idx[o] == 2'(r))) begin
                    out_do[DATA_W*o +: DATA_W] = llc_di_r[DATA_W*r +: DATA_W];
                end
            end
        end
    end

    // Wait counter next state. The count is cleared when the requester is
    // idle or is accepted. Otherwise it counts up and saturates at the limit.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            if (!llc_si_r[r] || llc_ri_r[r]) begin
                cnt_nxt[r] = '0;
            end else if (wait_cnt[r] == LIM_C) begin
                cnt_nxt[r] = LIM_C;
            end else begin
                cnt_nxt[r] = wait_cnt[r] + 1'b1;
            end
        end
    end

    // State update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (reset) begin
            // NOTE: the pointer and counter arrays are real arbitration state,
            // not data storage. They must be reset so that the first grant
            // after reset is deterministic (r0 > r1 > r2 > r3).
            for (int o = 0; o < 8; o++) ptr[o] <= '0;
            for (int r = 0; r < 4; r++) wait_cnt[r] <= '0;
            starve_q <= '0;
        end else begin
            // Pointers advance only on an actual transfer. A stalled output
            // keeps its pointer.
            for (int o = 0; o < 8; o++) begin
                if (grant[o]) ptr[o] <= win_idx[o] + 2'd1;
            end
            // Starve is taken from the updated count, so it becomes visible
            // one cycle after the count reaches the limit.
            for (int r = 0; r < 4; r++) begin
                wait_cnt[r] <= cnt_nxt[r];
                starve_q[r] <= (cnt_nxt[r] == LIM_C);
            end
        end
    end

endmodule

// File: tb/tb_cd_reply_rr_sched.sv
module tb_cd_reply_rr_sched;

    localparam int DW  = 64;
    localparam int LIM = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      si, ri;
    logic [4*DW-1:0] di;
    logic [7:0]      so, ro;
    logic [8*DW-1:0] dout;
    logic [3:0]      starve;

    int checks   = 0;
    int failures = 0;

    cd_reply_rr_sched #(.DATA_W(DW), .SX_LSB(40), .SY_LSB(32), .STARVE_LIM(LIM)) dut (
        .clk(clk), .reset(reset),
        .llc_si_r(si), .llc_ri_r(ri), .llc_di_r(di),
        .out_so(so), .out_ro(ro), .out_do(dout),
        .starve(starve)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] flit(input int tag, input int sx, input int sy);
        logic [63:0] f;
        f        = '0;
        f[31:0]  = 32'(tag);
        f[63:48] = 16'(tag);
        f[47:40] = 8'(sx);
        f[39:32] = 8'(sy);
        return f;
    endfunction

    task automatic set_req(input int r, input int sx, input int sy, input int tag);
        di[DW*r +: DW] = flit(tag, sx, sy);
    endtask

    // Place requester r's flit at output d. Bit 1 of d is sx[1]; bits 2 and 0 form sy.
    task automatic set_dest(input int r, input int d, input int tag);
        set_req(r, ((d >> 1) & 1) * 2, ((d >> 2) & 1) * 2 + (d & 1), tag);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_ptr [8];
    int m_cnt [4];
    int m_win [8];

    function automatic int dest_of(input logic [63:0] f);
        return (f[33] ? 4 : 0) + (f[41] ? 2 : 0) + (f[32] ? 1 : 0);
    endfunction

    task automatic model_eval(output logic [3:0] e_ri, output logic [7:0] e_so,
                              output logic [511:0] e_do);
        e_ri = '0; e_so = '0; e_do = '0;
        for (int o = 0; o < 8; o++) begin
            int starved_w, rr_w, best_dist;
            starved_w = -1; rr_w = -1; best_dist = 99;
            m_win[o] = -1;
            for (int r = 0; r < 4; r++) begin
                if (si[r] && dest_of(di[DW*r +: DW]) == o) begin
                    if (m_cnt[r] == LIM && starved_w < 0) starved_w = r;
                    if ((r - m_ptr[o] + 4) % 4 < best_dist) begin
                        best_dist = (r - m_ptr[o] + 4) % 4;
                        rr_w      = r;
                    end
                end
            end
            m_win[o] = (starved_w >= 0) ? starved_w : rr_w;
            if (!reset && m_win[o] >= 0 && ro[o]) begin
                e_so[o]          = 1'b1;
                e_ri[m_win[o]]   = 1'b1;
                e_do[DW*o +: DW] = di[DW*m_win[o] +: DW];
            end
        end
    endtask

    task automatic model_step(input logic [3:0] e_ri, input logic [7:0] e_so);
        if (reset) begin
            for (int o = 0; o < 8; o++) m_ptr[o] = 0;
            for (int r = 0; r < 4; r++) m_cnt[r] = 0;
        end else begin
            for (int o = 0; o < 8; o++) if (e_so[o]) m_ptr[o] = (m_win[o] + 1) % 4;
            for (int r = 0; r < 4; r++)
                m_cnt[r] = (!si[r] || e_ri[r]) ? 0 : ((m_cnt[r] + 1 > LIM) ? LIM : m_cnt[r] + 1);
        end
    endtask

    // ---------------- table vectors (distinct destinations) ----------------
    typedef struct {
        logic [3:0]  si;
        logic [7:0]  ro;
        logic [11:0] dst;   // 3 bits per requester, r0 in the low bits
        logic [3:0]  exp_ri;
        logic [7:0]  exp_so;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [3:0]   e_ri;
        logic [7:0]   e_so;
        logic [511:0] e_do;
        logic [3:0]   e_st;

        tbl[0] = '{4'b1111, 8'hFF, {3'd6, 3'd4, 3'd2, 3'd0}, 4'b1111, 8'b01010101};
        tbl[1] = '{4'b1111, 8'hFF, {3'd7, 3'd5, 3'd3, 3'd1}, 4'b1111, 8'b10101010};
        tbl[2] = '{4'b1111, 8'h0F, {3'd6, 3'd4, 3'd2, 3'd0}, 4'b0011, 8'b00000101};
        tbl[3] = '{4'b1010, 8'hFF, {3'd6, 3'd4, 3'd2, 3'd0}, 4'b1010, 8'b01000100};
        tbl[4] = '{4'b0000, 8'hFF, {3'd6, 3'd4, 3'd2, 3'd0}, 4'b0000, 8'b00000000};
        tbl[5] = '{4'b0101, 8'hDF, {3'd7, 3'd5, 3'd3, 3'd1}, 4'b0001, 8'b00000010};

        // Reset: outputs are forced low even with live requests.
        reset = 1'b1; ro = 8'hFF; di = '0;
        for (int r = 0; r < 4; r++) set_dest(r, r * 2, r);
        si = 4'b1111;
        #1;
        check("rst_so", so, 0);
        check("rst_ri", ri, 0);
        check("rst_do", dout, 0);
        tick(); tick();
        reset = 1'b0; si = 4'b0000;
        #1;
        check("rst_starve", starve, 0);

        // 1: distinct targets.
        set_req(0, 0, 0, 'h10); set_req(1, 2, 1, 'h11); si = 4'b0011; ro = 8'hFF;
        #1;
        check("t1_so", so, 8'b00001001);
        check("t1_ri", ri, 4'b0011);
        check("t1_o0", dout[0*DW +: DW], flit('h10, 0, 0));
        check("t1_o3", dout[3*DW +: DW], flit('h11, 2, 1));
        tick(); si = 4'b0000;

        // 2: round-robin conflict on output 5.
        set_req(0, 0, 3, 'h20); set_req(1, 0, 3, 'h21); si = 4'b0011;
        #1; check("t2_c1_ri", ri, 4'b0001); check("t2_c1_o5", dout[5*DW +: DW], flit('h20, 0, 3));
        tick(); check("t2_c2_ri", ri, 4'b0010); check("t2_c2_o5", dout[5*DW +: DW], flit('h21, 0, 3));
        tick(); check("t2_c3_ri", ri, 4'b0001); check("t2_c3_o5", dout[5*DW +: DW], flit('h20, 0, 3));
        tick(); si = 4'b0000;

        // 3: output not ready, requester starves.
        set_req(2, 3, 3, 'h30); si = 4'b0100; ro = 8'h7F;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("t3_so_%0d", i), so, 0);
            check($sformatf("t3_ri_%0d", i), ri, 0);
            if (i == 7) check("t3_starve_early", starve, 0);
            tick();
        end
        check("t3_starve", starve, 4'b0100);
        ro = 8'hFF;
        #1; check("t3_release_ri", ri, 4'b0100);
        tick(); si = 4'b0000;
        #1; check("t3_starve_clr", starve, 0);

        // 4: starvation overrides the rotating pointer.
        set_req(1, 2, 2, 'h40); si = 4'b0010;
        #1; check("t4_prime_ri", ri, 4'b0010);
        tick();                                   // ptr6 = 2
        ro = 8'hBF;
        for (int i = 0; i < 8; i++) tick();
        check("t4_starve", starve, 4'b0010);
        set_req(3, 2, 2, 'h43); si = 4'b1010; ro = 8'hFF;
        #1;
        check("t4_ri", ri, 4'b0010);
        check("t4_o6", dout[6*DW +: DW], flit('h40, 2, 2));
        tick(); si = 4'b1000;
        #1;
        check("t4_starve_clr", starve, 0);
        check("t4_r3_ri", ri, 4'b1000);
        tick(); si = 4'b0000;

        // 6: reset in mid-operation restores fixed priority.
        set_req(0, 0, 3, 'h60); si = 4'b0001;
        tick();                                   // ptr5 = 1
        set_req(2, 3, 3, 'h62); si = 4'b0100; ro = 8'h7F;
        for (int i = 0; i < 8; i++) tick();
        check("t6_starve_pre", starve, 4'b0100);
        reset = 1'b1; ro = 8'hFF;
        set_req(0, 0, 3, 'h60); set_req(1, 0, 3, 'h61); si = 4'b0011;
        #1;
        check("t6_rst_so", so, 0);
        check("t6_rst_ri", ri, 0);
        check("t6_rst_do", dout, 0);
        tick(); reset = 1'b0;
        #1;
        check("t6_starve", starve, 0);
        check("t6_ri", ri, 4'b0001);
        tick(); si = 4'b0000;

        // Table vectors, including 5: full throughput.
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < 4; r++) set_dest(r, int'(tbl[i].dst[3*r +: 3]), 'h500 + 16 * i + r);
            si = tbl[i].si; ro = tbl[i].ro;
            #1;
            check($sformatf("tbl%0d_ri", i), ri, tbl[i].exp_ri);
            check($sformatf("tbl%0d_so", i), so, tbl[i].exp_so);
            tick();
        end
        si = 4'b0000;

        // Randomized traffic against the reference model.
        begin
            logic [3:0]  pend;
            logic [63:0] pf [4];
            pend  = '0;
            reset = 1'b1;
            #1; model_eval(e_ri, e_so, e_do); model_step(e_ri, e_so);
            tick();
            for (int cyc = 0; cyc < 400; cyc++) begin
                reset = ($urandom_range(0, 99) == 0);
                for (int r = 0; r < 4; r++) begin
                    if (!pend[r] && $urandom_range(0, 99) < 60) begin
                        pend[r] = 1'b1;
                        pf[r]   = {$urandom, $urandom};
                    end
                    di[DW*r +: DW] = pf[r];
                end
                si = pend;
                ro = 8'($urandom) | 8'($urandom);
                #1;
                for (int r = 0; r < 4; r++) e_st[r] = (m_cnt[r] == LIM);
                model_eval(e_ri, e_so, e_do);
                check($sformatf("rnd%0d_ri", cyc), ri, e_ri);
                check($sformatf("rnd%0d_so", cyc), so, e_so);
                check($sformatf("rnd%0d_do", cyc), dout, e_do);
                check($sformatf("rnd%0d_starve", cyc), starve, e_st);
                model_step(e_ri, e_so);
                pend = pend & ~e_ri;
                tick();
            end
            reset = 1'b0; si = 4'b0000;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
